agc_mdt_injector: RTL and testbench
===================================

# agc_mdt_injector

Monitor data injector sitting directly upstream of the `agc` core's MDT01–MDT16 inputs in the simulation and FPGA test harness. It accepts 16-bit words from a host-side valid/ready queue, aligns each word to the core's MT01–MT12 timepulse outputs, and drives the word on MDT for a programmed timepulse window. It aborts cleanly on MGOJAM, so stimulus, such as forced bus data for monitor loads, is cycle-accurate relative to the AGC memory cycle.

## Interface
Parameters:
- `FIFO_DEPTH`, 4, request queue entries (power of two, ≥2)
- `SYNC_STAGES`, 2, synchronizer flops on MT/MGOJAM inputs (≥2)

Ports:
- `SIM_CLK`  in  1  sole clock, all state on rising edge
- `SIM_RST`  in  1  asynchronous, active-high reset
- `MT`  in  12  core timepulses MT01..MT12 (bit 0 = MT01)
- `MGOJAM`  in  1  core GOJAM monitor
- `req_valid`  in  1  host request present
- `req_ready`  out  1  queue can accept (= !full)
- `req_data`  in  16  word for MDT16..MDT01 (bit 15 = MDT16)
- `req_tp_start`  in  4  first timepulse of window, 1..12
- `req_tp_end`  in  4  last timepulse of window, req_tp_start..12
- `MDT`  out  16  to core MDT01..MDT16, registered
- `busy`  out  1  an entry is in ARM/WAIT/DRIVE
- `done`  out  1  one-cycle pulse: window completed
- `aborted`  out  1  one-cycle pulse: window killed by MGOJAM
- `req_err`  out  1  one-cycle pulse: invalid request rejected

## Operation
- Push on `req_valid && req_ready`. Invalid window (start 0 or >12, end >12, end < start) is not queued; `req_err` pulses the next cycle; handshake still completes.
- `MT` and `MGOJAM` pass through `SYNC_STAGES` flops. Rising edge of synced MTk yields event `tp_ev` with index k. When several bits rise in one cycle, the lowest index wins.
- FSM states IDLE, ARM, WAIT, DRIVE:
  - IDLE: if queue non-empty, pop to the active register and go to ARM next cycle. No same-cycle bypass.
  - ARM: wait for `tp_ev` index 1. If start==1, go to DRIVE. Otherwise go to WAIT.
  - WAIT: on `tp_ev` index == start, go to DRIVE.
  - DRIVE: `MDT` = word. On `tp_ev` index == end+1, or index 1 when end==12, set `MDT` = 0, pulse `done`, and go to IDLE.
- Abort: synced MGOJAM high in ARM, WAIT, or DRIVE sets `MDT` = 0, pulses `aborted`, discards the active entry, and goes to IDLE. Queued entries are retained. While MGOJAM stays high, IDLE does not pop.
- Out-of-order timepulse in WAIT/DRIVE (index 1 seen before expected index): treat as abort, same as MGOJAM.
- `MDT` is 0 in every state except DRIVE.

## Timing
- Reset values: `MDT`=0, `busy`=0, `done`=0, `aborted`=0, `req_err`=0, queue empty, `req_ready`=1, FSM=IDLE, sync flops 0.
- Input-edge to event latency: `SYNC_STAGES`+1 cycles after an MT bit rises at the pin.
- `MDT` updates on the cycle after the qualifying `tp_ev`. `done` and `aborted` assert in the same cycle that `MDT` returns to 0.
- Pop to ARM: 1 cycle. Back-to-back entries cannot share one memory cycle. The next entry re-arms on the following MT01.
- Queue full: `req_ready`=0 in the same cycle; pushes are ignored.
- Reset mid-DRIVE: `MDT` clears asynchronously and the queue is emptied.

## Structure
- Package `agc_mon_pkg`: FSM state enum, `TP_COUNT`=12, 4-bit timepulse index type, request struct {data, tp_start, tp_end}, window-validity function.
- Sub-module `agc_mt_sync`: synchronizer, rising-edge detect, and lowest-index encoder for MT plus synced MGOJAM. Outputs `tp_ev` and `tp_idx`.
- FIFO stays inline (small register array with pointers).

## Test plan
- Push data 16'o077777, start 3, end 5, then run MT01..MT12: `MDT` reads 16'o077777 from the cycle after the MT03 event until the cycle after the MT06 event; `done` pulses once.
- start 1, end 12: `MDT` is held from the cycle after MT01 until the cycle after the next MT01; `busy` is 1 throughout.
- start 7, end 4: `req_err` pulses, queue stays empty, `MDT` stays 0.
- Push 5 valid requests with depth 4: the fifth is refused (`req_ready`=0), and four windows are driven in order across four memory cycles.
- Assert MGOJAM during DRIVE: `MDT`=0 and `aborted` pulse; the remaining queued entry is driven after MGOJAM falls.
- Assert SIM_RST while DRIVE with 16'o177777: `MDT` drops to 0 without waiting for SIM_CLK; after release, `req_ready`=1 and `busy`=0.

Source files
------------

// File: rtl/agc_mon_pkg.sv
// agc_mon_pkg: shared types for the AGC monitor data injector
package agc_mon_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_DRIVE} state_e;
  localparam logic [3:0] TP_COUNT = 4'd12;
  typedef logic [3:0] tp_idx_t;
  typedef struct packed {
    logic [15:0] data;
    tp_idx_t     tp_start;
    tp_idx_t     tp_end;
  } mdt_req_t;
  function automatic logic win_ok(input tp_idx_t s, input tp_idx_t e);
    return (s != 4'd0) && (s <= TP_COUNT) && (e <= TP_COUNT) && (e >= s);
  endfunction
endpackage

// File: rtl/agc_mt_sync.sv
// agc_mt_sync: synchronizes MT/MGOJAM and reports the lowest rising timepulse
module agc_mt_sync
  import agc_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] mt_i,
  input  logic        mgojam_i,
  output logic        tp_ev,
  output tp_idx_t     tp_idx,
  output logic        mgojam_s_o
);
  logic [SYNC_STAGES-1:0][12:0] sync_q;
  logic [11:0] prev_q, rise;
  logic ev_q;
  tp_idx_t idx_q, idx_d;
  assign rise = sync_q[SYNC_STAGES-1][11:0] & ~prev_q;
  assign mgojam_s_o = sync_q[SYNC_STAGES-1][12];
  assign tp_ev = ev_q;
  assign tp_idx = idx_q;
  always_comb begin
    idx_d = '0;
    for (int i = 11; i >= 0; i--) if (rise[i]) idx_d = tp_idx_t'(i + 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
      ev_q   <= 1'b0;
      idx_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {mgojam_i, mt_i}};
      prev_q <= sync_q[SYNC_STAGES-1][11:0];
      ev_q   <= |rise;
      idx_q  <= idx_d;
    end
  end
endmodule

// File: rtl/agc_mdt_injector.sv
// agc_mdt_injector: queues host words and drives them on MDT inside a
// timepulse window of the AGC memory cycle, aborting on GOJAM.
module agc_mdt_injector
  import agc_mon_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic [11:0] MT,
  input  logic        MGOJAM,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_data,
  input  logic [3:0]  req_tp_start,
  input  logic [3:0]  req_tp_end,
  output logic [15:0] MDT,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        req_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  mdt_req_t mem_q [FIFO_DEPTH];
  logic [PW:0] wp_q, rp_q;
  logic full, empty, ok, push, pop, tp_ev, mg_s, end_hit;
  tp_idx_t tp_idx;
  state_e state_q, state_d;
  mdt_req_t act_q, act_d;
  logic [15:0] mdt_q, mdt_d;
  logic done_q, done_d, ab_q, ab_d, err_q;

  agc_mt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (SIM_CLK),
    .rst       (SIM_RST),
    .mt_i      (MT),
    .mgojam_i  (MGOJAM),
    .tp_ev     (tp_ev),
    .tp_idx    (tp_idx),
    .mgojam_s_o(mg_s)
  );

  assign full      = (wp_q ^ rp_q) == {1'b1, {PW{1'b0}}};
  assign empty     = wp_q == rp_q;
  assign ok        = win_ok(req_tp_start, req_tp_end);
  assign push      = req_valid && !full && ok;
  assign pop       = (state_q == S_IDLE) && !empty && !mg_s;
  assign req_ready = !full;
  assign MDT       = mdt_q;
  assign busy      = state_q != S_IDLE;
  assign done      = done_q;
  assign aborted   = ab_q;
  assign req_err   = err_q;

  always_ff @(posedge SIM_CLK) begin
    if (push) mem_q[wp_q[PW-1:0]] <= '{data: req_data, tp_start: req_tp_start, tp_end: req_tp_end};
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    done_d  = 1'b0;
    ab_d    = 1'b0;
    end_hit = tp_ev && (tp_idx == (act_q.tp_end == TP_COUNT ? 4'd1 : act_q.tp_end + 4'd1));
    case (state_q)
      S_IDLE: if (pop) begin
        act_d   = mem_q[rp_q[PW-1:0]];
        state_d = S_ARM;
      end
      S_ARM: if (tp_ev && tp_idx == 4'd1) state_d = act_q.tp_start == 4'd1 ? S_DRIVE : S_WAIT;
      S_WAIT: if (tp_ev && tp_idx == act_q.tp_start) state_d = S_DRIVE;
              else if (tp_ev && tp_idx == 4'd1) ab_d = 1'b1;
      S_DRIVE: if (end_hit) done_d = 1'b1;
               else if (tp_ev && tp_idx == 4'd1) ab_d = 1'b1;
      default: state_d = S_IDLE;
    endcase
    // GOJAM outranks any timepulse seen in the same cycle
    if (state_q != S_IDLE && mg_s) begin
      done_d = 1'b0;
      ab_d   = 1'b1;
    end
    if (done_d || ab_d) state_d = S_IDLE;
    mdt_d = state_d == S_DRIVE ? act_q.data : '0;
  end

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      wp_q    <= '0;
      rp_q    <= '0;
      state_q <= S_IDLE;
      act_q   <= '0;
      mdt_q   <= '0;
      done_q  <= 1'b0;
      ab_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wp_q    <= wp_q + {{PW{1'b0}}, push};
      rp_q    <= rp_q + {{PW{1'b0}}, pop};
      state_q <= state_d;
      act_q   <= act_d;
      mdt_q   <= mdt_d;
      done_q  <= done_d;
      ab_q    <= ab_d;
      err_q   <= req_valid && !full && !ok;
    end
  end
endmodule

// File: tb/tb_agc_mdt_injector.sv
// tb_agc_mdt_injector: directed scenarios plus random traffic against a window-level model
module tb_agc_mdt_injector;
  localparam int DEPTH = 4;
  localparam int L = 3;
  localparam int MC = 12 * L;
  typedef struct {
    logic [15:0] d;
    int s;
    int e;
  } req_t;

  logic SIM_CLK = 1'b0;
  logic SIM_RST = 1'b1;
  logic [11:0] MT = '0;
  logic MGOJAM = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [15:0] req_data = '0;
  logic [3:0] req_tp_start = '0;
  logic [3:0] req_tp_end = '0;
  logic [15:0] MDT;
  logic busy, done, aborted, req_err;

  int n_chk = 0, n_fail = 0, n_done = 0, n_ab = 0, mt_ph = 0, mg_hold = 0;
  bit chaos = 0;
  req_t mq[$];
  req_t act;
  bit act_v, armed, drv;
  logic [11:0] mth[5];
  bit mgh[3];
  logic [15:0] e_mdt;
  bit e_done, e_ab, e_err;

  agc_mdt_injector #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .MT(MT), .MGOJAM(MGOJAM),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_tp_start(req_tp_start), .req_tp_end(req_tp_end), .MDT(MDT),
    .busy(busy), .done(done), .aborted(aborted), .req_err(req_err)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int low_idx(input logic [11:0] r);
    for (int i = 0; i < 12; i++) if (r[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    act_v = 0; armed = 0; drv = 0;
    foreach (mth[k]) mth[k] = '0;
    foreach (mgh[k]) mgh[k] = 0;
    e_mdt = '0; e_done = 0; e_ab = 0; e_err = 0;
  endtask

  // Advances the reference by one clock edge using the inputs about to be sampled
  task automatic model_edge();
    int idx, sz, s, e;
    bit mg, fin, kill;
    for (int k = 4; k > 0; k--) mth[k] = mth[k-1];
    mth[0] = MT;
    mgh[2] = mgh[1]; mgh[1] = mgh[0]; mgh[0] = MGOJAM;
    idx = low_idx(mth[3] & ~mth[4]);
    mg = mgh[2];
    sz = mq.size();
    fin = 0; kill = 0;
    if (!act_v) begin
      if (sz > 0 && !mg) begin
        act = mq.pop_front();
        act_v = 1; armed = 0; drv = 0;
      end
    end else if (mg) kill = 1;
    else if (idx != 0) begin
      if (!armed) begin
        if (idx == 1) begin armed = 1; drv = (act.s == 1); end
      end else if (!drv) begin
        if (idx == act.s) drv = 1;
        else if (idx == 1) kill = 1;
      end else if (idx == (act.e % 12) + 1) fin = 1;
      else if (idx == 1) kill = 1;
    end
    if (fin || kill) begin act_v = 0; drv = 0; end
    e_done = fin; e_ab = kill; e_err = 0;
    s = int'(req_tp_start); e = int'(req_tp_end);
    if (req_valid && sz < DEPTH) begin
      if (s >= 1 && s <= 12 && e <= 12 && e >= s) mq.push_back('{req_data, s, e});
      else e_err = 1;
    end
    e_mdt = drv ? act.d : 16'h0;
  endtask

  task automatic check_all();
    chk("mdt", 32'(MDT), 32'(e_mdt));
    chk("done", 32'(done), 32'(e_done));
    chk("aborted", 32'(aborted), 32'(e_ab));
    chk("req_err", 32'(req_err), 32'(e_err));
    chk("req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
    chk("busy", 32'(busy), 32'(act_v));
    if (done) n_done++;
    if (aborted) n_ab++;
  endtask

  task automatic tick();
    if (!chaos) MT = 12'(1) << ((mt_ph / L) % 12);
    else if ($urandom_range(2) == 0) MT = 12'($urandom);
    mt_ph++;
    model_edge();
    @(posedge SIM_CLK);
    @(negedge SIM_CLK);
    check_all();
    req_valid = 1'b0;
  endtask

  task automatic push(input logic [15:0] d, input int s, input int e);
    req_valid = 1'b1;
    req_data = d;
    req_tp_start = 4'(s);
    req_tp_end = 4'(e);
    tick();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_drive(input string tag);
    for (int i = 0; i < 3 * MC && MDT == 16'h0; i++) tick();
    chk(tag, 32'(MDT != 16'h0), 32'd1);
  endtask

  initial begin
    int s, e;
    model_reset();
    repeat (2) @(negedge SIM_CLK);
    chk("rst_mdt", 32'(MDT), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    SIM_RST = 1'b0;
    run(5);

    n_done = 0;
    push(16'o077777, 3, 5);
    run(2 * MC + 10);
    chk("t1_done_cnt", 32'(n_done), 32'd1);

    n_done = 0;
    push(16'o123456, 1, 12);
    run(3 * MC);
    chk("t2_done_cnt", 32'(n_done), 32'd1);

    push(16'o052525, 7, 4);
    run(5);
    chk("t3_busy", 32'(busy), 32'd0);

    MGOJAM = 1'b1;
    run(4);
    for (int i = 0; i < 5; i++) begin
      s = $urandom_range(1, 12);
      e = $urandom_range(s, 12);
      push(16'($urandom_range(1, 16'hffff)), s, e);
    end
    chk("t4_ready", 32'(req_ready), 32'd0);
    MGOJAM = 1'b0;
    n_done = 0;
    run(6 * MC);
    chk("t4_done_cnt", 32'(n_done), 32'd4);

    push(16'o011111, 2, 10);
    push(16'o022222, 4, 6);
    wait_drive("t5_drive");
    n_ab = 0; n_done = 0;
    MGOJAM = 1'b1;
    run(6);
    MGOJAM = 1'b0;
    run(3 * MC);
    chk("t5_abort_cnt", 32'(n_ab), 32'd1);
    chk("t5_done_cnt", 32'(n_done), 32'd1);

    push(16'o177777, 1, 12);
    push(16'o000001, 2, 3);
    wait_drive("t6_drive");
    #2 SIM_RST = 1'b1;
    #1 chk("t6_async_mdt", 32'(MDT), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    @(negedge SIM_CLK);
    @(negedge SIM_CLK);
    SIM_RST = 1'b0;
    model_reset();
    chk("t6_ready", 32'(req_ready), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    run(3 * MC);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(399) == 0) chaos = !chaos;
      if (mg_hold > 0) mg_hold--;
      else if ($urandom_range(299) == 0) mg_hold = $urandom_range(2, 12);
      MGOJAM = mg_hold > 0;
      if ($urandom_range(7) == 0) begin
        req_valid = 1'b1;
        req_data = 16'($urandom);
        s = $urandom_range(1, 12);
        e = $urandom_range(s, 12);
        if ($urandom_range(5) == 0) begin
          s = $urandom_range(0, 15);
          e = $urandom_range(0, 15);
        end
        req_tp_start = 4'(s);
        req_tp_end = 4'(e);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
